// File: rtl/spi_slave_byte.sv
// SPI responder byte engine, CPHA=0, MSB first.
// Every SPI pin is oversampled in the clk domain. Received bytes are pushed
// downstream with a one-cycle wrreq. Transmit bytes come from a show-ahead
// FIFO. A byte is popped only once the master actually clocks its first bit.
module spi_slave_byte #(
    parameter bit CPOL        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       n_cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       empty,
    input  logic [7:0] data_i,
    output logic       rdreq,
    output logic [7:0] data_o,
    output logic       wrreq,
    output logic       busy,
    output logic       tx_underrun
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser chains. Bit 0 is the first stage; the MSB is the usable output.
    logic [SYNC_STAGES-1:0] ncs_pipe_reg;
    logic [SYNC_STAGES-1:0] sclk_pipe_reg;
    logic [SYNC_STAGES-1:0] mosi_pipe_reg;

    logic ncs_sync;
    logic sck_i;
    logic mosi_sync;

    state_t     state_reg,    state_next;
    logic [2:0] bit_cnt_reg,  bit_cnt_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic       tx_owned_reg, tx_owned_next;
    logic       sck_prev_reg;
    logic       miso_reg,     miso_next;
    logic       rdreq_reg,    rdreq_next;
    logic       wrreq_reg,    wrreq_next;
    logic [7:0] data_o_reg,   data_o_next;
    logic       underrun_reg, underrun_next;

    logic lead_edge;
    logic trail_edge;
    logic load_tx;

    // Shift the asynchronous SPI pins through the synchroniser stages. Reset loads the idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_pipe_reg  <= {SYNC_STAGES{1'b1}};
            sclk_pipe_reg <= {SYNC_STAGES{CPOL}};
            mosi_pipe_reg <= '0;
        end else begin
            ncs_pipe_reg  <= {ncs_pipe_reg[SYNC_STAGES-2:0], n_cs};
            sclk_pipe_reg <= {sclk_pipe_reg[SYNC_STAGES-2:0], sclk};
            mosi_pipe_reg <= {mosi_pipe_reg[SYNC_STAGES-2:0], mosi};
        end
    end

    assign ncs_sync  = ncs_pipe_reg[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe_reg[SYNC_STAGES-1];
    // Normalise polarity so a leading edge is always a 0->1 transition of sck_i.
    assign sck_i     = sclk_pipe_reg[SYNC_STAGES-1] ^ CPOL;

    // Edges count only inside an active frame and never in the frame start/end cycle.
    assign lead_edge  = (state_reg == ST_ACTIVE) && !ncs_sync &&  sck_i && !sck_prev_reg;
    assign trail_edge = (state_reg == ST_ACTIVE) && !ncs_sync && !sck_i &&  sck_prev_reg;

    // State register for the frame FSM, the shifters and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
            tx_shift_reg <= 8'h00;
            tx_owned_reg <= 1'b0;
            sck_prev_reg <= 1'b0;
            miso_reg     <= 1'b0;
            rdreq_reg    <= 1'b0;
            wrreq_reg    <= 1'b0;
            data_o_reg   <= 8'h00;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_shift_reg <= rx_shift_next;
            tx_shift_reg <= tx_shift_next;
            tx_owned_reg <= tx_owned_next;
            sck_prev_reg <= sck_i;
            miso_reg     <= miso_next;
            rdreq_reg    <= rdreq_next;
            wrreq_reg    <= wrreq_next;
            data_o_reg   <= data_o_next;
            underrun_reg <= underrun_next;
        end
    end

    // Next-state logic: frame start/end first, then the leading/trailing edge actions.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_shift_next = rx_shift_reg;
        tx_shift_next = tx_shift_reg;
        tx_owned_next = tx_owned_reg;
        rdreq_next    = 1'b0;
        wrreq_next    = 1'b0;
        data_o_next   = data_o_reg;
        underrun_next = 1'b0;
        miso_next     = 1'b0;
        load_tx       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!ncs_sync) begin
                    state_next   = ST_ACTIVE;
                    bit_cnt_next = 3'd0;
                    load_tx      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ncs_sync) begin
                    // The frame ended, possibly mid-byte. Any partial rx byte is simply dropped.
                    state_next    = ST_IDLE;
                    bit_cnt_next  = 3'd0;
                    tx_owned_next = 1'b0;
                end else if (lead_edge) begin
                    rx_shift_next = {rx_shift_reg[6:0], mosi_sync};
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd0 && tx_owned_reg) begin
                        rdreq_next    = 1'b1;
                        tx_owned_next = 1'b0;
                    end
                    if (bit_cnt_reg == 3'd7) begin
                        data_o_next = {rx_shift_reg[6:0], mosi_sync};
                        wrreq_next  = 1'b1;
                    end
                end else if (trail_edge) begin
                    if (bit_cnt_reg != 3'd0) begin
                        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                    end else begin
                        load_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Byte slot start: take the FIFO head if there is one. Do not pop yet.
        if (load_tx) begin
            if (!empty) begin
                tx_shift_next = data_i;
                tx_owned_next = 1'b1;
            end else begin
                tx_shift_next = 8'h00;
                tx_owned_next = 1'b0;
                underrun_next = 1'b1;
            end
        end

        // Drive miso from the upcoming shift value so it settles as early as possible.
        miso_next = !ncs_sync && tx_shift_next[7];
    end

    assign miso        = miso_reg;
    assign rdreq       = rdreq_reg;
    assign wrreq       = wrreq_reg;
    assign data_o      = data_o_reg;
    assign busy        = (state_reg == ST_ACTIVE);
    assign tx_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte. Two instances (CPOL=0 and CPOL=1) share one SPI master.
// The CPOL=1 instance sees the inverted clock, so both must behave identically.
// Expectations are queued by a frame-level reference model. A monitor process
// pops them and compares whenever the DUT presents an output.
module tb_spi_slave_byte;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic n_cs = 1'b1;
    logic sclk_lvl = 1'b0;
    logic sclk1;
    logic mosi = 1'b0;
    logic empty;
    logic [7:0] data_i;

    logic miso0, rdreq0, wrreq0, busy0, ur0;
    logic [7:0] data_o0;
    logic miso1, rdreq1, wrreq1, busy1, ur1;
    logic [7:0] data_o1;

    assign sclk1 = ~sclk_lvl;

    always #5 clk = ~clk;

    spi_slave_byte #(.CPOL(1'b0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk_lvl), .mosi(mosi),
        .miso(miso0), .empty(empty), .data_i(data_i), .rdreq(rdreq0),
        .data_o(data_o0), .wrreq(wrreq0), .busy(busy0), .tx_underrun(ur0)
    );

    spi_slave_byte #(.CPOL(1'b1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk1), .mosi(mosi),
        .miso(miso1), .empty(empty), .data_i(data_i), .rdreq(rdreq1),
        .data_o(data_o1), .wrreq(wrreq1), .busy(busy1), .tx_underrun(ur1)
    );

    // tx FIFO model. The stimulus process writes it; the monitor pops it on dut0 rdreq.
    logic [7:0] fifo_mem [256];
    int fifo_wr = 0;
    int fifo_rd = 0;
    assign empty  = (fifo_wr == fifo_rd);
    assign data_i = fifo_mem[fifo_rd % 256];

    // Reference-model state. Only the stimulus process writes these.
    logic [7:0] model_q [$];
    logic [7:0] m_out [4];
    logic [7:0] exp_rx [256];
    int exp_rx_wr = 0;
    logic [7:0] exp_m [256];
    int exp_m_wr = 0;
    logic [7:0] got_m0 [256];
    logic [7:0] got_m1 [256];
    int got_m_wr = 0;
    int exp_rd_tot = 0;
    int exp_ur_tot = 0;
    int chk_seq = 0;
    int rst_seq = 0;
    int busy_seq = 0;

    // Monitor state. Only the monitor process writes these.
    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt0 = 0, rd_cnt1 = 0;
    int ur_cnt0 = 0, ur_cnt1 = 0;
    int wr_seen0 = 0, wr_seen1 = 0;
    int m_rd = 0;
    int chk_done = 0;
    int rst_done = 0;
    int busy_done = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count pulses, pop the FIFO, and compare each DUT output against the scoreboard.
    always @(negedge clk) begin
        if (rdreq0) begin
            rd_cnt0++;
            fifo_rd++;
        end
        if (rdreq1) rd_cnt1++;
        if (ur0) ur_cnt0++;
        if (ur1) ur_cnt1++;
        if (wrreq0) begin
            if (wr_seen0 < exp_rx_wr) check("dut0 data_o", int'(data_o0), int'(exp_rx[wr_seen0 % 256]));
            else check("dut0 wrreq count", wr_seen0 + 1, exp_rx_wr);
            wr_seen0++;
        end
        if (wrreq1) begin
            if (wr_seen1 < exp_rx_wr) check("dut1 data_o", int'(data_o1), int'(exp_rx[wr_seen1 % 256]));
            else check("dut1 wrreq count", wr_seen1 + 1, exp_rx_wr);
            wr_seen1++;
        end
        while (m_rd < got_m_wr) begin
            check("dut0 master rx byte", int'(got_m0[m_rd % 256]), int'(exp_m[m_rd % 256]));
            check("dut1 master rx byte", int'(got_m1[m_rd % 256]), int'(exp_m[m_rd % 256]));
            m_rd++;
        end
        if (busy_seq != busy_done) begin
            check("dut0 busy in frame", int'(busy0), 1);
            check("dut1 busy in frame", int'(busy1), 1);
            busy_done = busy_seq;
        end
        if (rst_seq != rst_done) begin
            check("dut0 outputs in reset", int'({miso0, rdreq0, wrreq0, busy0, ur0, data_o0}), 0);
            check("dut1 outputs in reset", int'({miso1, rdreq1, wrreq1, busy1, ur1, data_o1}), 0);
            rst_done = rst_seq;
        end
        if (chk_seq != chk_done) begin
            check("dut0 rdreq total", rd_cnt0, exp_rd_tot);
            check("dut1 rdreq total", rd_cnt1, exp_rd_tot);
            check("dut0 underrun total", ur_cnt0, exp_ur_tot);
            check("dut1 underrun total", ur_cnt1, exp_ur_tot);
            check("dut0 wrreq total", wr_seen0, exp_rx_wr);
            check("dut1 wrreq total", wr_seen1, exp_rx_wr);
            check("dut0 busy idle", int'(busy0), 0);
            check("dut1 busy idle", int'(busy1), 0);
            check("fifo occupancy", fifo_wr - fifo_rd, model_q.size());
            chk_done = chk_seq;
        end
    end

    task automatic fifo_push(input logic [7:0] v);
        fifo_mem[fifo_wr % 256] = v;
        fifo_wr++;
        model_q.push_back(v);
    endtask

    // Frame-level model. With n full bytes and p trailing partial bits, the byte
    // slots take FIFO entries in order. Slots beyond the FIFO contents send 00
    // and count as underruns. There are n+1 load points. Only clocked slots pop.
    task automatic model_frame(input int n, input int p);
        int fl;
        int clocked;
        int pops;
        fl = model_q.size();
        clocked = n + ((p > 0) ? 1 : 0);
        pops = (clocked < fl) ? clocked : fl;
        for (int k = 0; k < n; k++) begin
            exp_rx[exp_rx_wr % 256] = m_out[k];
            exp_rx_wr++;
            exp_m[exp_m_wr % 256] = (k < fl) ? model_q[k] : 8'h00;
            exp_m_wr++;
        end
        exp_rd_tot += pops;
        exp_ur_tot += (n + 1 > fl) ? (n + 1 - fl) : 0;
        for (int k = 0; k < pops; k++) void'(model_q.pop_front());
    endtask

    // SPI master, CPHA=0. It uses an 8-clk half period and samples miso at each leading edge.
    task automatic master_frame(input int n, input int p);
        logic [7:0] r0, r1, ob;
        int nb;
        n_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b <= n; b++) begin
            nb = (b < n) ? 8 : p;
            if (nb == 0) break;
            r0 = 8'h00;
            r1 = 8'h00;
            ob = m_out[b];
            for (int i = 0; i < nb; i++) begin
                mosi = ob[7 - i];
                repeat (8) @(negedge clk);
                r0 = {r0[6:0], miso0};
                r1 = {r1[6:0], miso1};
                sclk_lvl = 1'b1;
                if (b == 0 && i == 0) busy_seq++;
                repeat (8) @(negedge clk);
                sclk_lvl = 1'b0;
            end
            if (nb == 8) begin
                got_m0[got_m_wr % 256] = r0;
                got_m1[got_m_wr % 256] = r1;
                got_m_wr++;
            end
        end
        repeat (8) @(negedge clk);
        n_cs = 1'b1;
        mosi = 1'b0;
        repeat (16) @(negedge clk);
        chk_seq++;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int n, input int p);
        $display("frame %s: bytes=%0d partial_bits=%0d fifo_depth=%0d mosi0=%02h",
                 tag, n, p, model_q.size(), m_out[0]);
        model_frame(n, p);
        master_frame(n, p);
    endtask

    // Reset arrives while bit 3 is being clocked. Only the first-slot pop has happened by then.
    task automatic reset_mid_frame();
        logic [7:0] ob;
        $display("frame reset-mid-frame");
        fifo_push(8'hB7);
        exp_rd_tot += 1;
        void'(model_q.pop_front());
        ob = 8'h9C;
        n_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = ob[7 - i];
            repeat (8) @(negedge clk);
            sclk_lvl = 1'b1;
            repeat (8) @(negedge clk);
            sclk_lvl = 1'b0;
        end
        mosi = ob[4];
        repeat (8) @(negedge clk);
        sclk_lvl = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        rst_seq++;
        repeat (3) @(negedge clk);
        n_cs = 1'b1;
        sclk_lvl = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk_seq++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int nf, n, p;
        // Power-on reset state.
        @(posedge clk);
        #1 rst_seq++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte: the FIFO holds 3C and the master sends A5.
        fifo_push(8'h3C);
        m_out[0] = 8'hA5;
        run_frame("single", 1, 0);

        reset_mid_frame();

        // Three-byte frame.
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
        m_out[0] = 8'hC1; m_out[1] = 8'hC2; m_out[2] = 8'hC3;
        run_frame("three", 3, 0);

        // Underrun: the FIFO is empty at frame start.
        m_out[0] = 8'h5A;
        run_frame("underrun", 1, 0);

        // Abort after 5 bits. Then a byte loaded at the boundary but never clocked stays in the FIFO.
        fifo_push(8'h6D);
        m_out[0] = 8'hE3;
        run_frame("abort", 0, 5);
        fifo_push(8'h92); fifo_push(8'h47);
        m_out[0] = 8'h81;
        run_frame("after-abort", 1, 0);
        m_out[0] = 8'h3E;
        run_frame("retained-head", 1, 0);

        // F0 both ways. The CPOL=1 instance is checked alongside.
        fifo_push(8'hF0);
        m_out[0] = 8'hF0;
        run_frame("f0", 1, 0);

        // Randomised frames.
        for (int t = 0; t < 10; t++) begin
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) fifo_push(8'($urandom_range(0, 255)));
            n = $urandom_range(0, 3);
            p = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            if (n == 0 && p == 0) n = 1;
            for (int k = 0; k < 4; k++) m_out[k] = 8'($urandom_range(0, 255));
            run_frame("random", n, p);
        end

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
